// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int LANE_W      = 8;
  localparam int LATENCY_MAX = 15;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Illegal access: misaligned word, or word index beyond the array.
  function automatic logic addr_fault(input logic [31:0] addr, input logic byte_acc,
                                      input int depth);
    return (!byte_acc && addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage load/store request and response bundle between the pipeline and the responder.
interface dmem_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic        MemByte;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemStall;
  logic        MemDone;
  logic        MemFault;

  modport master (
    output MemReq, MemWrite, MemByte, Addr, WriteData,
    input  ReadData, MemStall, MemDone, MemFault
  );

  modport slave (
    input  MemReq, MemWrite, MemByte, Addr, WriteData,
    output ReadData, MemStall, MemDone, MemFault
  );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane steering: write enables, merged store word and zero-extended load value.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module dmem_lane
  import mem_pkg::*;
(
  input  logic [31:0] word_dat,
  input  logic [1:0]  lane,
  input  logic        byte_acc,
  input  logic [31:0] st_dat,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic [31:0] ld_val
);

  always_comb begin
    be      = 4'hF;
    st_word = st_dat;
    ld_val  = word_dat;
    if (byte_acc) begin
      unique case (lane)
        LANE0: be = 4'b0001;
        LANE1: be = 4'b0010;
        LANE2: be = 4'b0100;
        LANE3: be = 4'b1000;
      endcase
      for (int i = 0; i < 4; i++) begin
        st_word[i*LANE_W +: LANE_W] = be[i] ? st_dat[LANE_W-1:0] : word_dat[i*LANE_W +: LANE_W];
      end
      ld_val = {24'b0, word_dat[lane*LANE_W +: LANE_W]};
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per request against a word array, with wait states.
// Latency: request first seen in cycle 0 completes with a MemDone pulse in cycle LATENCY.
// Backpressure: MemStall holds the pipeline from the request cycle until the DONE cycle.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  // Out-of-range settings are pulled into the legal window rather than breaking the counter.
  localparam int LAT = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : ((LATENCY < 1) ? 1 : LATENCY);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, exec;
  logic [31:0] lat_addr, lat_wdat;
  logic        lat_wr, lat_byte;
  logic [31:0] cur_addr, cur_wdat;
  logic        cur_wr, cur_byte, fault;
  logic [IDX_W-1:0] idx;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word, st_word, ld_val;
  logic [3:0]  be;
  logic [31:0] rdata_q;
  logic        fault_q;

  assign accept = (state == IDLE) && bus.MemReq;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    exec      = 1'b0;
    unique case (state)
      IDLE: if (bus.MemReq) begin
        cnt_nxt = 4'(LAT - 1);
        if (LAT == 1) begin
          state_nxt = DONE;
          exec      = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: if (cnt == 4'd1) begin
        state_nxt = DONE;
        cnt_nxt   = 4'd0;
        exec      = 1'b1;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Single-cycle accesses execute on the accepting edge, so they bypass the latches.
  assign cur_addr = (state == IDLE) ? bus.Addr      : lat_addr;
  assign cur_wdat = (state == IDLE) ? bus.WriteData : lat_wdat;
  assign cur_wr   = (state == IDLE) ? bus.MemWrite  : lat_wr;
  assign cur_byte = (state == IDLE) ? bus.MemByte   : lat_byte;

  assign fault   = addr_fault(cur_addr, cur_byte, DEPTH);
  assign idx     = cur_addr[IDX_W+1:2];
  assign rd_word = mem[idx];

  dmem_lane u_lane (
    .word_dat (rd_word),
    .lane     (cur_addr[1:0]),
    .byte_acc (cur_byte),
    .st_dat   (cur_wdat),
    .be       (be),
    .st_word  (st_word),
    .ld_val   (ld_val)
  );

  always_ff @(posedge clk) begin
    if (exec && cur_wr && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*LANE_W +: LANE_W] <= st_word[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_addr <= '0;
      lat_wdat <= '0;
      lat_wr   <= 1'b0;
      lat_byte <= 1'b0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr <= bus.Addr;
        lat_wdat <= bus.WriteData;
        lat_wr   <= bus.MemWrite;
        lat_byte <= bus.MemByte;
      end
      fault_q <= exec && fault;
      if (exec) begin
        if (fault)        rdata_q <= '0;
        else if (!cur_wr) rdata_q <= ld_val;
      end
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.MemFault = fault_q;
  assign bus.MemDone  = (state == DONE);
  assign bus.MemStall = reset && (accept || (state == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic        MemWrite = 1'b0;
  logic        MemByte = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic        sel = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [2][256];
  logic        known [2][256];
  logic [31:0] last_rd [2];
  logic        rd_known [2];

  dmem_responder_if b2();
  dmem_responder_if b1();

  assign b2.MemReq = req[0];
  assign b2.MemWrite = MemWrite;
  assign b2.MemByte = MemByte;
  assign b2.Addr = Addr;
  assign b2.WriteData = WriteData;
  assign b1.MemReq = req[1];
  assign b1.MemWrite = MemWrite;
  assign b1.MemByte = MemByte;
  assign b1.Addr = Addr;
  assign b1.WriteData = WriteData;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  wire [31:0] o_rd    = sel ? b1.ReadData : b2.ReadData;
  wire        o_stall = sel ? b1.MemStall : b2.MemStall;
  wire        o_done  = sel ? b1.MemDone  : b2.MemDone;
  wire        o_flt   = sel ? b1.MemFault : b2.MemFault;

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic int lat(input int s);
    return (s == 1) ? 1 : 2;
  endfunction

  // Reference: plain word array, little-endian byte lanes.
  task automatic model(input int s, input logic wr, input logic byt, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] e_rd, output logic e_flt);
    int unsigned w;
    int sh;
    w = a / 4;
    sh = 8 * int'(a % 4);
    e_flt = (!byt && (a % 4) != 0) || (w >= 256);
    if (e_flt) begin
      last_rd[s] = '0;
      rd_known[s] = 1'b1;
    end else if (wr) begin
      if (byt) mdl[s][w] = (mdl[s][w] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      else begin
        mdl[s][w] = wd;
        known[s][w] = 1'b1;
      end
    end else begin
      last_rd[s] = byt ? ((mdl[s][w] >> sh) & 32'hFF) : mdl[s][w];
      rd_known[s] = known[s][w];
    end
    e_rd = last_rd[s];
  endtask

  // Drives one request, holds it through DONE, and reports what the DUT did.
  task automatic access(input int s, input logic wr, input logic byt, input logic [31:0] a,
                        input logic [31:0] wd, output int done_cyc, output int stalls,
                        output logic [31:0] rd, output logic flt, output logic post_busy);
    sel = (s == 1);
    @(posedge clk); #1;
    MemWrite = wr; MemByte = byt; Addr = a; WriteData = wd;
    req[s] = 1'b1;
    done_cyc = -1; stalls = 0; rd = '0; flt = 1'b0;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (o_stall) stalls++;
      if (o_done) begin
        done_cyc = c; rd = o_rd; flt = o_flt;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    req[s] = 1'b0;
    @(negedge clk);
    post_busy = o_done | o_stall | o_flt;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b2.ReadData !== 32'h0 || b2.MemDone !== 1'b0 || b2.MemFault !== 1'b0 || b2.MemStall !== 1'b0) begin
      errors++;
      $display("FAIL reset_l2: rd=%h done=%b fault=%b stall=%b, required all 0",
               b2.ReadData, b2.MemDone, b2.MemFault, b2.MemStall);
    end
    checks++;
    if (b1.ReadData !== 32'h0 || b1.MemDone !== 1'b0 || b1.MemFault !== 1'b0 || b1.MemStall !== 1'b0) begin
      errors++;
      $display("FAIL reset_l1: rd=%h done=%b fault=%b stall=%b, required all 0",
               b1.ReadData, b1.MemDone, b1.MemFault, b1.MemStall);
    end
    req = 2'b11; #1;
    checks++;
    if (b2.MemStall !== 1'b0 || b1.MemStall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: stall2=%b stall1=%b with request in reset, required 0",
               b2.MemStall, b1.MemStall);
    end
    req = 2'b00;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd, e_rd; logic flt, e_flt, pb; int dc, st;
    model(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, e_rd, e_flt);
    access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, dc, st, rd, flt, pb);
    checks++;
    if (dc !== 2 || st !== 2) begin
      errors++; $display("FAIL store_latency: done_cycle=%0d stalls=%0d, required 2/2", dc, st);
    end
    checks++;
    if (flt !== 1'b0 || pb !== 1'b0) begin
      errors++; $display("FAIL store_pulse: fault=%b after_done_busy=%b, required 0/0", flt, pb);
    end
    model(0, 1'b0, 1'b0, 32'h10, 32'h0, e_rd, e_flt);
    access(0, 1'b0, 1'b0, 32'h10, 32'h0, dc, st, rd, flt, pb);
    checks++;
    if (rd !== 32'hDEADBEEF || flt !== 1'b0) begin
      errors++; $display("FAIL load_word: rd=%h fault=%b, required deadbeef/0", rd, flt);
    end
    checks++;
    if (dc !== 2 || st !== 2 || pb !== 1'b0) begin
      errors++; $display("FAIL load_latency: done_cycle=%0d stalls=%0d busy=%b, required 2/2/0", dc, st, pb);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd, e_rd; logic flt, e_flt, pb; int dc, st;
    model(0, 1'b1, 1'b1, 32'h11, 32'hA5A5A55A, e_rd, e_flt);
    access(0, 1'b1, 1'b1, 32'h11, 32'hA5A5A55A, dc, st, rd, flt, pb);
    checks++;
    if (rd !== 32'hDEADBEEF || flt !== 1'b0) begin
      errors++; $display("FAIL store_holds_rd: rd=%h fault=%b, required deadbeef/0", rd, flt);
    end
    model(0, 1'b0, 1'b0, 32'h10, 32'h0, e_rd, e_flt);
    access(0, 1'b0, 1'b0, 32'h10, 32'h0, dc, st, rd, flt, pb);
    checks++;
    if (rd !== 32'hDEAD5AEF) begin
      errors++; $display("FAIL byte_merge: rd=%h, required dead5aef", rd);
    end
    model(0, 1'b0, 1'b1, 32'h13, 32'h0, e_rd, e_flt);
    access(0, 1'b0, 1'b1, 32'h13, 32'h0, dc, st, rd, flt, pb);
    checks++;
    if (rd !== 32'h000000DE || flt !== 1'b0) begin
      errors++; $display("FAIL byte_load_lane3: rd=%h fault=%b, required 000000de/0", rd, flt);
    end
  endtask

  task automatic test_fault();
    logic [31:0] rd, e_rd; logic flt, e_flt, pb; int dc, st;
    model(0, 1'b0, 1'b0, 32'h12, 32'h0, e_rd, e_flt);
    access(0, 1'b0, 1'b0, 32'h12, 32'h0, dc, st, rd, flt, pb);
    checks++;
    if (flt !== 1'b1 || rd !== 32'h0 || dc !== 2) begin
      errors++; $display("FAIL misaligned: fault=%b rd=%h done_cycle=%0d, required 1/0/2", flt, rd, dc);
    end
    checks++;
    if (pb !== 1'b0) begin
      errors++; $display("FAIL fault_clears: busy_after_done=%b, required 0", pb);
    end
    model(0, 1'b1, 1'b0, 32'h400, 32'h0BADF00D, e_rd, e_flt);
    access(0, 1'b1, 1'b0, 32'h400, 32'h0BADF00D, dc, st, rd, flt, pb);
    checks++;
    if (flt !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL out_of_range: fault=%b rd=%h, required 1/0", flt, rd);
    end
    model(0, 1'b0, 1'b0, 32'h10, 32'h0, e_rd, e_flt);
    access(0, 1'b0, 1'b0, 32'h10, 32'h0, dc, st, rd, flt, pb);
    checks++;
    if (rd !== 32'hDEAD5AEF || flt !== 1'b0) begin
      errors++; $display("FAIL fault_no_write: rd=%h fault=%b, required dead5aef/0", rd, flt);
    end
    model(0, 1'b1, 1'b0, 32'h3FC, 32'h8899AABB, e_rd, e_flt);
    access(0, 1'b1, 1'b0, 32'h3FC, 32'h8899AABB, dc, st, rd, flt, pb);
    model(0, 1'b0, 1'b1, 32'h3FF, 32'h0, e_rd, e_flt);
    access(0, 1'b0, 1'b1, 32'h3FF, 32'h0, dc, st, rd, flt, pb);
    checks++;
    if (rd !== 32'h00000088 || flt !== 1'b0) begin
      errors++; $display("FAIL last_byte: rd=%h fault=%b, required 00000088/0", rd, flt);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] rd, e_rd; logic flt, e_flt, pb; int dc, st;
    logic exp_stall;
    model(1, 1'b1, 1'b0, 32'h10, 32'h01020304, e_rd, e_flt);
    access(1, 1'b1, 1'b0, 32'h10, 32'h01020304, dc, st, rd, flt, pb);
    checks++;
    if (dc !== 1 || st !== 1 || pb !== 1'b0) begin
      errors++; $display("FAIL l1_store_latency: done_cycle=%0d stalls=%0d busy=%b, required 1/1/0", dc, st, pb);
    end
    model(1, 1'b0, 1'b0, 32'h10, 32'h0, e_rd, e_flt);
    sel = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0; MemByte = 1'b0; Addr = 32'h10;
    req[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_stall = (c % 2 == 0);
      checks++;
      if (b1.MemStall !== exp_stall || b1.MemDone !== !exp_stall ||
          (!exp_stall && b1.ReadData !== 32'h01020304)) begin
        errors++;
        $display("FAIL l1_back_to_back c%0d: stall=%b done=%b rd=%h, required %b/%b/01020304",
                 c, b1.MemStall, b1.MemDone, b1.ReadData, exp_stall, !exp_stall);
      end
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, e_rd; logic flt, e_flt, pb; int dc, st;
    model(0, 1'b1, 1'b0, 32'h20, 32'h0, e_rd, e_flt);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, dc, st, rd, flt, pb);
    sel = 1'b0;
    @(posedge clk); #1;
    MemWrite = 1'b1; MemByte = 1'b0; Addr = 32'h20; WriteData = 32'h12345678;
    req[0] = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (b2.MemStall !== 1'b1 || b2.ReadData === 32'h0) begin
      errors++; $display("FAIL abort_setup: stall=%b rd=%h, required 1/nonzero", b2.MemStall, b2.ReadData);
    end
    reset = 1'b0; req = 2'b00;
    #1;
    checks++;
    if (b2.ReadData !== 32'h0 || b2.MemStall !== 1'b0 || b2.MemDone !== 1'b0 || b2.MemFault !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: rd=%h stall=%b done=%b fault=%b, required all 0",
               b2.ReadData, b2.MemStall, b2.MemDone, b2.MemFault);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    model(0, 1'b0, 1'b0, 32'h20, 32'h0, e_rd, e_flt);
    access(0, 1'b0, 1'b0, 32'h20, 32'h0, dc, st, rd, flt, pb);
    checks++;
    if (rd !== e_rd || flt !== 1'b0 || dc !== 2) begin
      errors++; $display("FAIL abort_store_dropped: rd=%h fault=%b done_cycle=%0d, required %h/0/2", rd, flt, dc, e_rd);
    end
  endtask

  task automatic test_toggle();
    logic [31:0] rd, e_rd; logic flt, e_flt, pb; int dc, st;
    model(0, 1'b1, 1'b0, 32'h28, 32'h11111111, e_rd, e_flt);
    access(0, 1'b1, 1'b0, 32'h28, 32'h11111111, dc, st, rd, flt, pb);
    model(0, 1'b1, 1'b0, 32'h24, 32'hCAFEF00D, e_rd, e_flt);
    sel = 1'b0;
    @(posedge clk); #1;
    MemWrite = 1'b1; MemByte = 1'b0; Addr = 32'h24; WriteData = 32'hCAFEF00D;
    req[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      Addr = (c == 0) ? 32'h28 : 32'h25;
      WriteData = $urandom;
      MemByte = c[0];
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    model(0, 1'b0, 1'b0, 32'h24, 32'h0, e_rd, e_flt);
    access(0, 1'b0, 1'b0, 32'h24, 32'h0, dc, st, rd, flt, pb);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL toggle_latched: rd=%h, required cafef00d", rd);
    end
    model(0, 1'b0, 1'b0, 32'h28, 32'h0, e_rd, e_flt);
    access(0, 1'b0, 1'b0, 32'h28, 32'h0, dc, st, rd, flt, pb);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++; $display("FAIL toggle_untouched: rd=%h, required 11111111", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, e_rd, a, wd; logic flt, e_flt, pb, wr, byt; int dc, st, s, kind;
    for (int w = 0; w < 16; w++) begin
      for (int d = 0; d < 2; d++) begin
        wd = $urandom;
        model(d, 1'b1, 1'b0, 32'(w * 4), wd, e_rd, e_flt);
        access(d, 1'b1, 1'b0, 32'(w * 4), wd, dc, st, rd, flt, pb);
      end
    end
    for (int n = 0; n < 80; n++) begin
      s = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      byt = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind < 8)       a = 32'($urandom_range(0, 63));
      else if (kind == 8) a = 32'($urandom_range(1020, 1027));
      else                a = $urandom;
      if (!byt && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd = $urandom;
      model(s, wr, byt, a, wd, e_rd, e_flt);
      access(s, wr, byt, a, wd, dc, st, rd, flt, pb);
      checks++;
      if (dc !== lat(s) || st !== lat(s) || flt !== e_flt || pb !== 1'b0 ||
          (rd_known[s] && rd !== e_rd)) begin
        errors++;
        $display("FAIL random[%0d] dut%0d wr=%b byte=%b addr=%h: done=%0d stalls=%0d fault=%b rd=%h busy=%b, required %0d/%0d/%b/%h/0",
                 n, s, wr, byt, a, dc, st, flt, rd, pb, lat(s), lat(s), e_flt, e_rd);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin
        mdl[d][i] = '0;
        known[d][i] = 1'b0;
      end
      last_rd[d] = '0;
      rd_known[d] = 1'b1;
    end
    test_reset();
    test_store_load();
    test_byte();
    test_fault();
    test_latency1();
    test_reset_abort();
    test_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the memory stage of the pipelined ARM core.
- Accepts the load/store request the pipeline presents in the M stage (address, store data, byte/word, read/write) and serves it after a configurable number of wait states.
- Holds the pipeline with a stall output while the request is outstanding, then returns registered load data with a one-cycle done pulse.
- Models a slow external RAM so the hazard/stall logic is exercised by real multi-cycle memory.

Parameters:
- DEPTH, 256, number of 32-bit words in the array; byte address range is 0 .. 4*DEPTH-1.
- LATENCY, 2, cycles from request acceptance to DONE; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- MemReq  input  1  request valid; the pipeline holds it and all request fields stable while MemStall=1.
- MemWrite  input  1  1 = store, 0 = load.
- MemByte  input  1  1 = byte access, 0 = word access.
- Addr  input  32  byte address.
- WriteData  input  32  store data; byte stores use bits [7:0].
- ReadData  output  32  registered load result.
- MemStall  output  1  combinational stall to the pipeline (StallF/StallD/M-hold).
- MemDone  output  1  one-cycle pulse when the access completes.
- MemFault  output  1  registered; 1 for one cycle with MemDone when the access was illegal.

Behaviour:
- States: IDLE, WAIT, DONE. Internal counter cnt is 4 bits.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0.
  - ReadData=0, MemDone=0, MemFault=0.
  - Latched request registers cleared. Array contents are not reset.
- IDLE:
  - MemReq=0: remain in IDLE.
  - MemReq=1: latch Addr, WriteData, MemWrite and MemByte; set cnt=LATENCY-1; next state is DONE if LATENCY==1, otherwise WAIT.
- WAIT:
  - cnt==1: go to DONE. The access executes on this edge using the latched fields.
  - Otherwise: decrement cnt.
  - For LATENCY==1 the access executes on the IDLE→DONE edge instead.
- DONE:
  - MemDone=1; ReadData and MemFault are valid.
  - Always returns to IDLE next cycle. A request seen in DONE belongs to the completing access and is ignored.
- MemStall = (state==IDLE & MemReq) | (state==WAIT). It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency: request first seen in cycle 0 gives DONE in cycle LATENCY, with exactly LATENCY stall cycles.
- Fault conditions:
  - Word access with Addr[1:0]!=0.
  - Addr[31:2] >= DEPTH.
- On fault: no array write; ReadData=0; MemFault=1 in DONE.
- Word load: ReadData = mem[Addr[31:2]].
- Byte load:
  - Little-endian; lane selected by Addr[1:0].
  - Lane 0 = bits [7:0], lane 3 = bits [31:24].
  - Result is zero-extended to 32 bits.
- Word store: writes all 4 bytes.
- Byte store: writes only the selected lane with WriteData[7:0]. Other lanes are untouched.
- After any store, ReadData holds its previous value.
- ReadData holds its value between accesses. MemFault clears to 0 after DONE.
- Request fields changing during WAIT: ignored, because the latched copy is used.
- Reset asserted mid-access (WAIT or DONE):
  - Aborts immediately; returns to IDLE, all outputs are 0.
  - A pending store is not performed.
  - A store that completed on an earlier edge remains.

Decomposition:
- Shared package (mem_pkg):
  - State encoding: IDLE=2'b00, WAIT=2'b01, DONE=2'b10.
  - Lane-select constants and a byte-lane width constant (8).
  - LATENCY range limit constant (15).
- Sub-module dmem_lane (combinational):
  - Inputs: word, Addr[1:0], MemByte, store data.
  - Outputs: 4-bit byte write-enable, merged store word, extracted/zero-extended load value.
- Top level holds the FSM, counter, latches, fault check and array.

Test Plan:
- LATENCY=2:
  - Store word 0xDEADBEEF to 0x10; MemStall is high in cycles 0-1 and MemDone pulses in cycle 2.
  - A load from 0x10 then returns ReadData=0xDEADBEEF in its DONE cycle with MemFault=0.
- Byte store 0x5A to 0x11 over 0xDEADBEEF → a word load of 0x10 returns 0xDEAD5AEF; a byte load of 0x13 returns 0x000000DE.
- Word load from 0x12 (misaligned), then a store to 4*DEPTH → each gives MemFault=1 with MemDone; no array word changes (reload 0x10 is unchanged); ReadData=0.
- LATENCY=1 (re-parameterised):
  - Back-to-back requests with MemReq held high → each completes in 1 stall cycle + DONE.
  - MemReq seen in DONE does not start a second access.
- reset=0 pulsed during WAIT of a store of 0x12345678 to 0x20 → outputs go to 0 asynchronously, state is IDLE, and a later load of 0x20 does not return 0x12345678 (pre-initialised to 0).
- Addr/WriteData toggled every cycle during WAIT → the stored value equals the value latched at acceptance.
